// File: rtl/button_events_pkg.sv
// Shared types and default timing for the button gesture decoder.
// Counter width is sized so the longer of the two thresholds always fits without wrapping.
package button_events_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2
    } state_e;

    localparam int DEF_N             = 4;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    function automatic int cnt_width(input int hold_cycles, input int repeat_cycles);
        int m;
        m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_events_chan.sv
// One button channel: IDLE/SHORT/LONG state machine with a per-channel cycle counter
// producing registered press/release/tap/hold/repeat pulses and the long level.
module button_events_chan
    import button_events_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press,
    output logic rel,
    output logic tap,
    output logic hold,
    output logic rpt,
    output logic long
);

    localparam int               CNT_W     = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               RPT_EN    = (REPEAT_CYCLES > 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             tap_q, tap_d;
    logic             hold_q, hold_d;
    logic             rpt_q, rpt_d;

    // Release is tested first in every pressed state so it wins over a coincident threshold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        tap_d   = 1'b0;
        hold_d  = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn) begin
                    state_d = ST_SHORT;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_SHORT: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                    tap_d   = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    hold_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (RPT_EN && (cnt_q == RPT_LAST)) begin
                    cnt_d = '0;
                    rpt_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            tap_q   <= 1'b0;
            hold_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            tap_q   <= tap_d;
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
        end
    end

    assign press = press_q;
    assign rel   = rel_q;
    assign tap   = tap_q;
    assign hold  = hold_q;
    assign rpt   = rpt_q;
    assign long  = (state_q == ST_LONG);

endmodule

// File: rtl/button_events.sv
// N independent button gesture channels sharing one clock and reset.
// The release output is named rel because release is a reserved word.
module button_events
    import button_events_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] btn,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] tap,
    output logic [N-1:0] hold,
    output logic [N-1:0] rpt,
    output logic [N-1:0] long
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        button_events_chan #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clock(clock),
            .reset(reset),
            .btn  (btn[i]),
            .press(press[i]),
            .rel  (rel[i]),
            .tap  (tap[i]),
            .hold (hold[i]),
            .rpt  (rpt[i]),
            .long (long[i])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: per-edge expected pulses from hand-written event tables,
// plus hand sequences for asynchronous reset and a repeat-disabled build.
module tb_button_events;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_TAP   = 2;
    localparam int K_HOLD  = 3;
    localparam int K_RPT   = 4;
    localparam int K_LONG  = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn   = '0;
    logic [3:0] btn_z = '0;
    logic [3:0] press, rel, tap, hold, rpt, long;
    logic [3:0] press_z, rel_z, tap_z, hold_z, rpt_z, long_z;

    int tests_run = 0;
    int tests_failed = 0;

    button_events #(.N(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)) dut (
        .clock(clock), .reset(reset), .btn(btn),
        .press(press), .rel(rel), .tap(tap), .hold(hold), .rpt(rpt), .long(long)
    );

    button_events #(.N(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(0)) dut_z (
        .clock(clock), .reset(reset), .btn(btn_z),
        .press(press_z), .rel(rel_z), .tap(tap_z), .hold(hold_z), .rpt(rpt_z), .long(long_z)
    );

    always #5 clock = ~clock;

    // Channels 0-3 are dut, 4-7 are dut_z; edges are numbered from 1 within a segment.
    typedef struct { int ch; int on; int off; } pulse_t;
    typedef struct { int e; int ch; int kind; } evt_t;
    typedef struct { int ch; int from; int to; } lvl_t;

    pulse_t pulses[$];
    evt_t   evts[$];
    lvl_t   levels[$];

    function automatic logic [47:0] bundle();
        return {press_z, press, rel_z, rel, tap_z, tap, hold_z, hold, rpt_z, rpt, long_z, long};
    endfunction

    function automatic logic [47:0] bit_of(input int kind, input int ch);
        logic [47:0] v;
        v = '0;
        v[(5 - kind) * 8 + ch] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [47:0] exp);
        logic [47:0] act;
        act = bundle();
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got press/rel/tap/hold/rpt/long=%012h expected %012h", name, act, exp);
        end
    endtask

    task automatic add_pulse(input int ch, input int on, input int off);
        pulse_t p;
        p.ch = ch; p.on = on; p.off = off;
        pulses.push_back(p);
    endtask

    task automatic add_evt(input int e, input int ch, input int kind);
        evt_t v;
        v.e = e; v.ch = ch; v.kind = kind;
        evts.push_back(v);
    endtask

    task automatic add_long(input int ch, input int from, input int to);
        lvl_t l;
        l.ch = ch; l.from = from; l.to = to;
        levels.push_back(l);
    endtask

    task automatic run_seg(input string seg, input int n_edges);
        for (int e = 1; e <= n_edges; e++) begin
            logic [7:0]  b;
            logic [47:0] exp;
            b = '0;
            foreach (pulses[i])
                if (pulses[i].on <= e && e < pulses[i].off) b[pulses[i].ch] = 1'b1;
            btn   = b[3:0];
            btn_z = b[7:4];
            @(posedge clock);
            #1;
            exp = '0;
            foreach (evts[i])
                if (evts[i].e == e) exp |= bit_of(evts[i].kind, evts[i].ch);
            foreach (levels[i])
                if (levels[i].from <= e && e < levels[i].to) exp |= bit_of(K_LONG, levels[i].ch);
            check($sformatf("%s_e%0d", seg, e), exp);
        end
        pulses.delete();
        evts.delete();
        levels.delete();
    endtask

    initial begin
        #12;
        check("reset_state", '0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_reset", '0);

        // Tap on channel 0: five cycles high
        add_pulse(0, 1, 6);
        add_evt(1, 0, K_PRESS);
        add_evt(6, 0, K_REL);
        add_evt(6, 0, K_TAP);
        run_seg("tap", 10);

        // Long press with repeat on channel 1: twenty cycles high
        add_pulse(1, 1, 21);
        add_evt(1, 1, K_PRESS);
        add_evt(9, 1, K_HOLD);
        add_evt(12, 1, K_RPT);
        add_evt(15, 1, K_RPT);
        add_evt(18, 1, K_RPT);
        add_evt(21, 1, K_REL);
        add_long(1, 9, 21);
        run_seg("long", 24);

        // Release on the hold threshold (ch2) and on the repeat threshold (ch3)
        add_pulse(2, 1, 9);
        add_evt(1, 2, K_PRESS);
        add_evt(9, 2, K_REL);
        add_evt(9, 2, K_TAP);
        add_pulse(3, 1, 12);
        add_evt(1, 3, K_PRESS);
        add_evt(9, 3, K_HOLD);
        add_evt(12, 3, K_REL);
        add_long(3, 9, 12);
        run_seg("collide", 15);

        // All four pressed together, released after 2, 9, 12, 30 cycles
        for (int c = 0; c < 4; c++) add_evt(1, c, K_PRESS);
        add_pulse(0, 1, 3);
        add_evt(3, 0, K_REL);
        add_evt(3, 0, K_TAP);
        add_pulse(1, 1, 10);
        add_evt(9, 1, K_HOLD);
        add_evt(10, 1, K_REL);
        add_long(1, 9, 10);
        add_pulse(2, 1, 13);
        add_evt(9, 2, K_HOLD);
        add_evt(12, 2, K_RPT);
        add_evt(13, 2, K_REL);
        add_long(2, 9, 13);
        add_pulse(3, 1, 31);
        add_evt(9, 3, K_HOLD);
        for (int r = 12; r <= 30; r += 3) add_evt(r, 3, K_RPT);
        add_evt(31, 3, K_REL);
        add_long(3, 9, 31);
        run_seg("indep", 34);

        // Repeat-disabled build, channel 0 held for 40 cycles
        add_pulse(4, 1, 41);
        add_evt(1, 4, K_PRESS);
        add_evt(9, 4, K_HOLD);
        add_evt(41, 4, K_REL);
        add_long(4, 9, 41);
        run_seg("norpt", 44);

        // Asynchronous reset in LONG on channel 3, button kept down across deassertion
        btn = 4'b1000;
        @(posedge clock);
        #1;
        check("rst_seq_press", bit_of(K_PRESS, 3));
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rst_seq_short%0d", i), '0);
        end
        @(posedge clock);
        #1;
        check("rst_seq_hold", bit_of(K_HOLD, 3) | bit_of(K_LONG, 3));
        @(posedge clock);
        #1;
        check("rst_seq_long", bit_of(K_LONG, 3));
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_clear", '0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rst_held%0d", i), '0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_repress", bit_of(K_PRESS, 3));
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rst_reshort%0d", i), '0);
        end
        @(posedge clock);
        #1;
        check("rst_rehold", bit_of(K_HOLD, 3) | bit_of(K_LONG, 3));
        btn = '0;
        @(posedge clock);
        #1;
        check("rst_release", bit_of(K_REL, 3));
        @(posedge clock);
        #1;
        check("rst_idle", '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
